// File: rtl/memory_writer_wiener_output_pkg.sv
// rtl/memory_writer_wiener_output_pkg.sv - shared state type and AXI constants for the Wiener output writer
// Purpose: write-FSM state encoding and fixed AXI field values used by the
//          memory_writer_wiener_output slice.
// Ports:   none (package).
package wiener_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ADDR,
        DATA,
        RESP,
        DONE
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;

endpackage

// File: rtl/memory_writer_wiener_output_if.sv
// rtl/memory_writer_wiener_output_if.sv - AXI4 write-channel bundle for the Wiener output writer
// Purpose: groups the AW, W and B channel signals of one AXI4 write port.
// Ports:   master - drives aw*/w*/bready, samples awready/wready/bvalid/bresp
//          slave  - the interconnect side, directions reversed
interface memory_writer_wiener_output_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/memory_writer_wiener_output_block_addr_gen.sv
// rtl/memory_writer_wiener_output_block_addr_gen.sv - block-raster position counters and burst address register
// Purpose: tracks col_blk/row_blk/py for the current burst, holds the frame
//          geometry latched at start, and registers the burst start address.
// Ports:   clk, rst_n       clock, asynchronous active-low reset
//          start            frame accepted: latch base/geometry, clear counters
//          base_addr_in     frame base address (pixel units)
//          frame_width/height  frame geometry in pixels
//          calc             load addr with the address of the current burst
//          advance          step to the next block row (py, then col, then row)
//          frame_empty      no complete block fits in the presented geometry
//          last_burst       current burst is the final one of the frame
//          addr             registered burst start address
module block_addr_gen
    import wiener_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic                  calc,
    input  logic                  advance,
    output logic                  frame_empty,
    output logic                  last_burst,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam int         LOG2_BS = $clog2(BLOCK_SIZE);
    localparam logic [3:0] PY_LAST = 4'(BLOCK_SIZE - 1);

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]           width_q, width_d;
    logic [15:0]           nbx_q, nbx_d;
    logic [15:0]           nby_q, nby_d;
    logic [15:0]           col_blk_q, col_blk_d;
    logic [15:0]           row_blk_q, row_blk_d;
    logic [3:0]            py_q, py_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [15:0] nbx_in;
    logic [15:0] nby_in;
    logic [31:0] row_pix;
    logic [31:0] row_off;
    logic [31:0] col_pix;
    logic        py_wrap;
    logic        col_wrap;

    // Partial blocks at the right/bottom edge are dropped by the truncating shift.
    assign nbx_in      = frame_width  >> LOG2_BS;
    assign nby_in      = frame_height >> LOG2_BS;
    assign frame_empty = (nbx_in == 16'd0) || (nby_in == 16'd0);

    assign py_wrap    = (py_q == PY_LAST);
    assign col_wrap   = (col_blk_q == nbx_q - 16'd1);
    assign last_burst = py_wrap && col_wrap && (row_blk_q == nby_q - 16'd1);

    // Multiply is only captured on calc, so the AXI address path sees a flop.
    assign row_pix = ({16'd0, row_blk_q} << LOG2_BS) + {28'd0, py_q};
    assign row_off = row_pix * {16'd0, width_q};
    assign col_pix = {16'd0, col_blk_q} << LOG2_BS;

    always_comb begin
        base_d    = base_q;
        width_d   = width_q;
        nbx_d     = nbx_q;
        nby_d     = nby_q;
        col_blk_d = col_blk_q;
        row_blk_d = row_blk_q;
        py_d      = py_q;
        addr_d    = addr_q;

        if (start) begin
            base_d    = base_addr_in;
            width_d   = frame_width;
            nbx_d     = nbx_in;
            nby_d     = nby_in;
            col_blk_d = 16'd0;
            row_blk_d = 16'd0;
            py_d      = 4'd0;
        end

        if (calc) begin
            addr_d = base_q + ADDR_WIDTH'(row_off + col_pix);
        end

        if (advance) begin
            if (!py_wrap) begin
                py_d = py_q + 4'd1;
            end else begin
                py_d = 4'd0;
                if (!col_wrap) begin
                    col_blk_d = col_blk_q + 16'd1;
                end else begin
                    col_blk_d = 16'd0;
                    row_blk_d = row_blk_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            width_q   <= '0;
            nbx_q     <= '0;
            nby_q     <= '0;
            col_blk_q <= '0;
            row_blk_q <= '0;
            py_q      <= '0;
            addr_q    <= '0;
        end else begin
            base_q    <= base_d;
            width_q   <= width_d;
            nbx_q     <= nbx_d;
            nby_q     <= nby_d;
            col_blk_q <= col_blk_d;
            row_blk_q <= row_blk_d;
            py_q      <= py_d;
            addr_q    <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/memory_writer_wiener_output.sv
// rtl/memory_writer_wiener_output.sv - AXI4 write master storing the Wiener-filtered frame in block-raster order
// Purpose: one INCR burst of BLOCK_SIZE beats per block row, one burst in flight,
//          pulses frame_written when the last write response returns.
// Config:  WRITE_RESP_CHECK_EN - when defined, a non-OKAY bresp sets sticky wr_error
//          (cleared by the next accepted start_frame); otherwise wr_error is 0.
// Ports:   clk, rst_n                 clock, asynchronous active-low reset
//          frame_height/frame_width   frame geometry in pixels
//          base_addr_in, start_frame  base address sampled on the start pulse
//          pixel_valid/data/ready     upstream pixel stream (passed straight to W)
//          axi                        AXI4 write master (AW, W, B channels)
//          busy                       not IDLE
//          frame_written              one-cycle end-of-frame pulse
//          wr_error                   sticky write-response error
module memory_writer_wiener_output
    import wiener_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  frame_height,
    input  logic [15:0]                  frame_width,
    input  logic [ADDR_WIDTH-1:0]        base_addr_in,
    input  logic                         start_frame,
    input  logic                         pixel_valid,
    input  logic [DATA_WIDTH-1:0]        pixel_data,
    output logic                         pixel_ready,
    memory_writer_wiener_output_if.master axi,
    output logic                         busy,
    output logic                         frame_written,
    output logic                         wr_error
);
    localparam logic [3:0] BEAT_LAST = 4'(BLOCK_SIZE - 1);

    wr_state_e state_q, state_d;
    logic [3:0] beat_q, beat_d;

    logic                  start_accept;
    logic                  addr_load;
    logic                  advance;
    logic                  frame_empty;
    logic                  last_burst;
    logic [ADDR_WIDTH-1:0] burst_addr;

    logic                  aw_valid;
    logic                  w_valid;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  b_ready;

    block_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_accept),
        .base_addr_in (base_addr_in),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .calc         (addr_load),
        .advance      (advance),
        .frame_empty  (frame_empty),
        .last_burst   (last_burst),
        .addr         (burst_addr)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        start_accept  = 1'b0;
        addr_load     = 1'b0;
        advance       = 1'b0;
        aw_valid      = 1'b0;
        w_valid       = 1'b0;
        w_last        = 1'b0;
        w_data        = '0;
        b_ready       = 1'b0;
        pixel_ready   = 1'b0;
        frame_written = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    start_accept = 1'b1;
                    beat_d       = 4'd0;
                    state_d      = frame_empty ? DONE : CALC;
                end
            end
            CALC: begin
                addr_load = 1'b1;
                state_d   = ADDR;
            end
            ADDR: begin
                aw_valid = 1'b1;
                if (axi.awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Pixel stream and W channel are one handshake; beat holds on stalls.
                w_valid     = pixel_valid;
                pixel_ready = axi.wready;
                w_data      = pixel_data;
                w_last      = (beat_q == BEAT_LAST);
                if (pixel_valid && axi.wready) begin
                    if (w_last) begin
                        beat_d  = 4'd0;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            RESP: begin
                b_ready = 1'b1;
                if (axi.bvalid) begin
                    advance = 1'b1;
                    state_d = last_burst ? DONE : CALC;
                end
            end
            DONE: begin
                frame_written = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

`ifdef WRITE_RESP_CHECK_EN
    logic wr_error_q, wr_error_d;
    logic resp_err;

    assign resp_err = (state_q == RESP) && axi.bvalid && (axi.bresp != AXI_RESP_OKAY);

    always_comb begin
        wr_error_d = wr_error_q;
        if (start_accept) begin
            wr_error_d = 1'b0;
        end else if (resp_err) begin
            wr_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_error_q <= 1'b0;
        end else begin
            wr_error_q <= wr_error_d;
        end
    end

    // Raised in the same cycle the bad response is seen, then held by the flop.
    assign wr_error = wr_error_q | resp_err;
`else
    logic unused_bresp;
    assign unused_bresp = ^axi.bresp;
    assign wr_error     = 1'b0;
`endif

    assign busy        = (state_q != IDLE);
    assign axi.awvalid = aw_valid;
    assign axi.awaddr  = burst_addr;
    assign axi.awlen   = 8'(BLOCK_SIZE - 1);
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wvalid  = w_valid;
    assign axi.wdata   = w_data;
    assign axi.wlast   = w_last;
    assign axi.bready  = b_ready;

endmodule

// File: tb/tb_memory_writer_wiener_output.sv
// tb/tb_memory_writer_wiener_output.sv - directed self-checking bench for memory_writer_wiener_output
module tb_memory_writer_wiener_output;
    import wiener_mem_pkg::*;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          BS   = 8;
    localparam logic [31:0] PIX0 = 32'hA500_0000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    frame_height;
    logic [15:0]    frame_width;
    logic [AW-1:0]  base_addr_in;
    logic           start_frame;
    logic           pixel_valid;
    logic [DW-1:0]  pixel_data;
    logic           pixel_ready;
    logic           busy;
    logic           frame_written;
    logic           wr_error;

    always #5 clk = ~clk;

    memory_writer_wiener_output_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    memory_writer_wiener_output #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_height  (frame_height),
        .frame_width   (frame_width),
        .base_addr_in  (base_addr_in),
        .start_frame   (start_frame),
        .pixel_valid   (pixel_valid),
        .pixel_data    (pixel_data),
        .pixel_ready   (pixel_ready),
        .axi           (axi),
        .busy          (busy),
        .frame_written (frame_written),
        .wr_error      (wr_error)
    );

    int n_cmp;
    int n_err;
    int cyc;
    int start_cyc;
    int first_aw_cyc;
    int last_b_cyc;
    int fw_cyc;
    int err_first_cyc;
    int b_err_cyc;
    int aw_valid_cnt;
    int fw_cnt;
    int b_cnt;
    int px_acc;
    int wstall;
    int err_at;
    int inject_at;
    bit stall_mode;
    bit toggle_mode;
    bit wr_err_seen;
    logic [AW-1:0] inject_base;
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    logic          wl_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int w, input int idx);
        int nbx;
        int py;
        int cb;
        int rb;
        nbx = w / BS;
        py  = idx % BS;
        cb  = (idx / BS) % nbx;
        rb  = idx / (BS * nbx);
        return base + 32'((rb * BS + py) * w + cb * BS);
    endfunction

    task automatic clear_mon();
        aw_q.delete();
        w_q.delete();
        wl_q.delete();
        first_aw_cyc  = -1;
        last_b_cyc    = -1;
        fw_cyc        = -1;
        err_first_cyc = -1;
        b_err_cyc     = -1;
        aw_valid_cnt  = 0;
        fw_cnt        = 0;
        b_cnt         = 0;
        px_acc        = 0;
        wstall        = 0;
        wr_err_seen   = 1'b0;
    endtask

    // Observe at negedge, then drive the interconnect/upstream side just after posedge.
    task automatic cycle();
        @(negedge clk);
        if (axi.awvalid) begin
            if (first_aw_cyc < 0) first_aw_cyc = cyc;
            aw_valid_cnt++;
        end
        if (axi.awvalid && axi.awready) begin
            aw_q.push_back(axi.awaddr);
            wstall = stall_mode ? 3 : 0;
        end
        if (axi.wvalid && axi.wready) begin
            w_q.push_back(axi.wdata);
            wl_q.push_back(axi.wlast);
        end
        if (pixel_valid && pixel_ready) px_acc++;
        if (axi.bvalid && axi.bready) begin
            if (b_cnt == err_at) b_err_cyc = cyc;
            b_cnt++;
            last_b_cyc = cyc;
        end
        if (wr_error) begin
            wr_err_seen = 1'b1;
            if (err_first_cyc < 0) err_first_cyc = cyc;
        end
        if (frame_written) begin
            fw_cnt++;
            fw_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        axi.awready = 1'b1;
        axi.wready  = (wstall == 0);
        if (wstall > 0) wstall--;
        pixel_valid = toggle_mode ? 1'(cyc & 1) : 1'b1;
        pixel_data  = PIX0 + 32'(px_acc);
        axi.bvalid  = 1'b1;
        axi.bresp   = (b_cnt == err_at) ? 2'b10 : 2'b00;
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input logic [AW-1:0] base);
        int n;
        clear_mon();
        frame_width  = w;
        frame_height = h;
        base_addr_in = base;
        start_cyc    = cyc;
        start_frame  = 1'b1;
        cycle();
        start_frame  = 1'b0;
        base_addr_in = 32'hDEAD_0000;
        n = 0;
        while (fw_cnt == 0 && n < 3000) begin
            if (cyc == inject_at) begin
                start_frame  = 1'b1;
                base_addr_in = inject_base;
            end else begin
                start_frame = 1'b0;
            end
            cycle();
            n++;
        end
        start_frame = 1'b0;
        chk("frame_done_in_budget", 64'(fw_cnt != 0), 64'd1);
        repeat (4) cycle();
    endtask

    task automatic check_frame(input string tag, input logic [31:0] base, input int w, input int nb);
        chk({tag, "_aw_count"}, 64'(aw_q.size()), 64'(nb));
        for (int i = 0; i < nb && i < aw_q.size(); i++)
            chk({tag, "_awaddr"}, 64'(aw_q[i]), 64'(exp_addr(base, w, i)));
        chk({tag, "_w_count"}, 64'(w_q.size()), 64'(nb * BS));
        chk({tag, "_px_count"}, 64'(px_acc), 64'(nb * BS));
        for (int i = 0; i < nb * BS && i < w_q.size(); i++) begin
            chk({tag, "_wdata"}, 64'(w_q[i]), 64'(PIX0 + 32'(i)));
            chk({tag, "_wlast"}, 64'(wl_q[i]), 64'((i % BS) == BS - 1));
        end
        chk({tag, "_fw_pulses"}, 64'(fw_cnt), 64'd1);
    endtask

    initial begin
        int n;
        n_cmp        = 0;
        n_err        = 0;
        cyc          = 0;
        err_at       = -1;
        inject_at    = -1;
        inject_base  = '0;
        stall_mode   = 1'b0;
        toggle_mode  = 1'b0;
        rst_n        = 1'b0;
        start_frame  = 1'b0;
        frame_width  = '0;
        frame_height = '0;
        base_addr_in = '0;
        pixel_valid  = 1'b0;
        pixel_data   = '0;
        axi.awready  = 1'b0;
        axi.wready   = 1'b0;
        axi.bvalid   = 1'b0;
        axi.bresp    = 2'b00;
        clear_mon();

        repeat (3) cycle();
        chk("reset_ctrl_outputs", 64'({busy, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                                       pixel_ready, frame_written, wr_error}), 64'd0);
        chk("reset_awaddr", 64'(axi.awaddr), 64'd0);
        chk("reset_wdata", 64'(axi.wdata), 64'd0);
        chk("const_awlen", 64'(axi.awlen), 64'd7);
        chk("const_awsize", 64'(axi.awsize), 64'd2);
        chk("const_awburst", 64'(axi.awburst), 64'd1);
        rst_n = 1'b1;
        repeat (2) cycle();
        chk("idle_after_reset", 64'(busy), 64'd0);

        // 16x16 frame, no backpressure
        run_frame(16'd16, 16'd16, 32'h1000);
        check_frame("full", 32'h1000, 16, 32);
        if (aw_q.size() == 32) begin
            chk("full_aw0", 64'(aw_q[0]), 64'h1000);
            chk("full_aw1", 64'(aw_q[1]), 64'h1010);
            chk("full_aw7", 64'(aw_q[7]), 64'h1070);
            chk("full_aw8", 64'(aw_q[8]), 64'h1008);
            chk("full_aw31", 64'(aw_q[31]), 64'h10F8);
        end
        chk("start_to_awvalid", 64'(first_aw_cyc - start_cyc), 64'd2);
        chk("lastb_to_fw", 64'(fw_cyc - last_b_cyc), 64'd1);
        chk("idle_after_frame", 64'(busy), 64'd0);

        // Same frame with toggling pixel_valid and 3 wready stall cycles per burst
        stall_mode  = 1'b1;
        toggle_mode = 1'b1;
        run_frame(16'd16, 16'd16, 32'h1000);
        check_frame("stall", 32'h1000, 16, 32);
        stall_mode  = 1'b0;
        toggle_mode = 1'b0;

        // 20x12 -> 2x1 blocks
        run_frame(16'd20, 16'd12, 32'h2000);
        check_frame("partial", 32'h2000, 20, 16);
        if (aw_q.size() == 16) begin
            chk("partial_aw1", 64'(aw_q[1]), 64'h2014);
            chk("partial_aw8", 64'(aw_q[8]), 64'h2008);
            chk("partial_aw15", 64'(aw_q[15]), 64'h2094);
        end
        chk("partial_ready_idle", 64'(pixel_ready), 64'd0);

        // 8x4 -> no full block row of blocks
        run_frame(16'd8, 16'd4, 32'h5000);
        chk("empty_no_awvalid", 64'(aw_valid_cnt), 64'd0);
        chk("empty_fw_pulses", 64'(fw_cnt), 64'd1);
        chk("empty_fw_latency", 64'((fw_cyc - start_cyc) >= 1 && (fw_cyc - start_cyc) <= 2), 64'd1);
        chk("empty_px_count", 64'(px_acc), 64'd0);

        // start_frame while busy is ignored
        inject_at   = cyc + 40;
        inject_base = 32'h9000;
        run_frame(16'd16, 16'd16, 32'h3000);
        inject_at   = -1;
        check_frame("inject", 32'h3000, 16, 32);
        chk("inject_idle", 64'(busy), 64'd0);

        // Reset in DATA at beat 3
        clear_mon();
        frame_width  = 16'd16;
        frame_height = 16'd16;
        base_addr_in = 32'h6000;
        start_frame  = 1'b1;
        cycle();
        start_frame = 1'b0;
        n = 0;
        while (w_q.size() < 3 && n < 100) begin
            cycle();
            n++;
        end
        chk("pre_rst_beats", 64'(w_q.size()), 64'd3);
        chk("pre_rst_wvalid", 64'(axi.wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_outputs", 64'({busy, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                                     pixel_ready, frame_written, wr_error}), 64'd0);
        chk("rst_awaddr", 64'(axi.awaddr), 64'd0);
        chk("rst_wdata", 64'(axi.wdata), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        run_frame(16'd16, 16'd16, 32'h1000);
        check_frame("after_rst", 32'h1000, 16, 32);

        // Error response on burst 5
        err_at = 4;
        run_frame(16'd16, 16'd16, 32'h4000);
        err_at = -1;
        chk("err_fw_pulses", 64'(fw_cnt), 64'd1);
        chk("err_aw_count", 64'(aw_q.size()), 64'd32);
`ifdef WRITE_RESP_CHECK_EN
        chk("err_seen", 64'(b_err_cyc >= 0 && err_first_cyc >= 0), 64'd1);
        chk("err_same_cycle", 64'(err_first_cyc - b_err_cyc), 64'd0);
        chk("err_sticky", 64'(wr_error), 64'd1);
        run_frame(16'd8, 16'd4, 32'h5000);
        chk("err_cleared_by_start", 64'(wr_error), 64'd0);
`else
        chk("err_tied_low", 64'(wr_err_seen), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
